// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among NUM_REQ
// valid/ready byte streams, with a watchdog on the tx_start/tx_busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       lock_active,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(START_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  wdog_cnt;
    logic           cur_last;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand_id;
    int             scan_idx;

    // Scan downward so the requester nearest rr_ptr+1 is the last one assigned.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_id   = '0;
        scan_idx  = 0;
        if (lock_active) begin
            win_found = req_valid[grant_id];
            win_id    = grant_id;
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                cand_id = IDW'(scan_idx);
                if (req_valid[cand_id]) begin
                    win_found = 1'b1;
                    win_id    = cand_id;
                end
            end
        end
    end

    // Reset is asynchronous and state already reads IDLE, so gate it explicitly.
    always_comb begin
        req_ready = '0;
        if (!wb_rst_i && state == ST_IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            lock_active <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= IDW'(NUM_REQ - 1);
            wdog_cnt    <= '0;
            cur_last    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        tx_data  <= req_data[{win_id, 3'b000} +: 8];
                        cur_last <= req_last[win_id];
                        grant_id <= win_id;
                        tx_start <= 1'b1;
                        wdog_cnt <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_busy) begin
                        state <= ST_DRAIN;
                    end else if (wdog_cnt == CW'(START_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: drop the byte and release the packet.
                        tx_start    <= 1'b0;
                        timeout_err <= 1'b1;
                        lock_active <= 1'b0;
                        rr_ptr      <= grant_id;
                        state       <= ST_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cur_last) begin
                        lock_active <= 1'b0;
                        rr_ptr      <= grant_id;
                    end else begin
                        lock_active <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a scripted UART responder and a
// byte-level arbitration model compared against the DUT on every cycle.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           lock_active;
    logic           timeout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .lock_active(lock_active),
        .timeout_err(timeout_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int errors = 0;
    int checks = 0;

    // Pending bytes per requester: bit 8 is the packet-last flag.
    logic [8:0] rq [N][$];

    // UART responder: busy rises u_d cycles into START and lasts u_f cycles.
    int u_d = 1;
    int u_f = 2;
    bit u_mute = 1'b0;

    // Byte-level model of the arbiter.
    bit         m_out;
    int         m_since;
    int         m_lock;
    int         m_rr;
    int         m_grant;
    int         m_owner;
    bit         m_cur_last;
    bit         m_mute_byte;
    logic [7:0] m_byte;
    bit         m_to_now;

    int         acc_ids[$];
    bit         acc_lock[$];
    logic [7:0] rx_log[$];
    int         to_delta[$];
    int         cyc = 0;
    int         rise_cyc = 0;
    bit         prev_start = 1'b0;
    int         n_start_hi = 0;
    int         n_ready_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out       = 1'b0;
        m_since     = 0;
        m_lock      = -1;
        m_rr        = N - 1;
        m_grant     = 0;
        m_owner     = 0;
        m_cur_last  = 1'b0;
        m_mute_byte = 1'b0;
        m_byte      = 8'h00;
        prev_start  = 1'b0;
    endtask

    // Requester that must win given the valid vector, or -1.
    function automatic int pick(input logic [N-1:0] v);
        int j;
        if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_rr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Cycle (counted from acceptance) in which the arbiter is free again.
    function automatic int end_since();
        return m_mute_byte ? TO + 1 : u_d + u_f + 3;
    endfunction

    // Last cycle (counted from acceptance) with tx_start high.
    function automatic int last_hi();
        return m_mute_byte ? TO : u_d + u_f + 1;
    endfunction

    // Drive requesters and UART at negedge, then compare 1 time unit later.
    initial begin
        int exp_win;
        int exp_ready;
        bit exp_start;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        model_reset();
        forever begin
            @(negedge wb_clk_i);
            cyc++;
            m_to_now = 1'b0;
            if (wb_rst_i) begin
                model_reset();
            end else if (m_out) begin
                m_since++;
                if (m_since == end_since()) begin
                    if (m_mute_byte || m_cur_last) begin
                        m_lock = -1;
                        m_rr   = m_owner;
                    end else begin
                        m_lock = m_owner;
                    end
                    m_to_now = m_mute_byte;
                    m_out    = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end
            end
            tx_busy = m_out && !m_mute_byte && (m_since >= 1 + u_d) && (m_since <= u_d + u_f);
            #1;
            if (!wb_rst_i) begin
                exp_win   = m_out ? -1 : pick(req_valid);
                exp_ready = (exp_win >= 0) ? (1 << exp_win) : 0;
                exp_start = m_out && (m_since >= 1) && (m_since <= last_hi());
                check("req_ready", req_ready, exp_ready);
                check("tx_start", tx_start, exp_start);
                if (exp_start) check("tx_data", tx_data, m_byte);
                check("timeout_err", timeout_err, m_to_now);
                check("lock_active", lock_active, m_lock >= 0);
                check("grant_id", grant_id, m_grant);

                if (tx_start && !prev_start) rise_cyc = cyc;
                if (timeout_err) to_delta.push_back(cyc - rise_cyc);
                prev_start = tx_start;
                if (tx_start) n_start_hi++;
                if (req_ready != '0) n_ready_hi++;
                if (tx_busy && m_since == 1 + u_d) rx_log.push_back(tx_data);

                if (exp_win >= 0) begin
                    m_out       = 1'b1;
                    m_since     = 0;
                    m_owner     = exp_win;
                    m_grant     = exp_win;
                    m_byte      = rq[exp_win][0][7:0];
                    m_cur_last  = rq[exp_win][0][8];
                    m_mute_byte = u_mute;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        acc_ids.push_back(i);
                        acc_lock.push_back(lock_active);
                        if (rq[i].size() > 0) void'(rq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        acc_ids.delete();
        acc_lock.delete();
        rx_log.delete();
        to_delta.delete();
        n_start_hi = 0;
        n_ready_hi = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rq[i].delete();
        @(posedge wb_clk_i);
        #3 wb_rst_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #3 wb_rst_i = 1'b0;
        clear_logs();
    endtask

    function automatic bit busy_any();
        bit b = m_out;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while (busy_any() && n < budget) begin
            @(posedge wb_clk_i);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: traffic still pending after %0d cycles", name, budget);
        end
        repeat (2) @(posedge wb_clk_i);
    endtask

    task automatic check_ids(input string name, input int exp[$]);
        check({name, "_len"}, acc_ids.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_ids.size(); i++)
            check($sformatf("%s[%0d]", name, i), acc_ids[i], exp[i]);
    endtask

    task automatic check_rx(input string name, input int exp[$]);
        check({name, "_len"}, rx_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_log.size(); i++)
            check($sformatf("%s[%0d]", name, i), rx_log[i], exp[i]);
    endtask

    initial begin
        int e[$];
        int n;
        wb_rst_i = 1'b1;
        #2;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_lock", lock_active, 0);
        check("rst_timeout", timeout_err, 0);

        // Single byte from requester 2.
        do_reset();
        u_d = 1; u_f = 10; u_mute = 1'b0;
        rq[2].push_back(9'h141);
        wait_quiet(200, "t1");
        e = '{2};            check_ids("t1_ids", e);
        e = '{8'h41};        check_rx("t1_rx", e);
        check("t1_ready_cycles", n_ready_hi, 1);
        check("t1_start_cycles", n_start_hi, 12);
        check("t1_lock_at_acc", acc_lock.size() > 0 ? acc_lock[0] : 1'b1, 0);

        // Round-robin from reset, then after a first grant to requester 1.
        do_reset();
        u_d = 1; u_f = 2;
        rq[0].push_back(9'h110); rq[0].push_back(9'h110);
        rq[1].push_back(9'h111); rq[2].push_back(9'h112); rq[3].push_back(9'h113);
        wait_quiet(200, "t2a");
        e = '{0, 1, 2, 3, 0};                    check_ids("t2a_ids", e);
        e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10}; check_rx("t2a_rx", e);
        do_reset();
        rq[1].push_back(9'h111);
        wait_quiet(100, "t2b_pre");
        clear_logs();
        for (int i = 0; i < N; i++) rq[i].push_back(9'h110 + 9'(i));
        wait_quiet(200, "t2b");
        e = '{2, 3, 0, 1};                 check_ids("t2b_ids", e);
        e = '{8'h12, 8'h13, 8'h10, 8'h11}; check_rx("t2b_rx", e);

        // Packet lock: "AB" from requester 1 while requester 0 waits.
        do_reset();
        rq[0].push_back(9'h130);
        wait_quiet(100, "t3_pre");
        clear_logs();
        rq[1].push_back(9'h041); rq[1].push_back(9'h142);
        rq[0].push_back(9'h131);
        wait_quiet(200, "t3");
        e = '{1, 1, 0};              check_ids("t3_ids", e);
        e = '{8'h41, 8'h42, 8'h31};  check_rx("t3_rx", e);
        check("t3_lock_len", acc_lock.size(), 3);
        if (acc_lock.size() == 3) begin
            check("t3_lock_A", acc_lock[0], 0);
            check("t3_lock_B", acc_lock[1], 1);
            check("t3_lock_next", acc_lock[2], 0);
        end

        // Watchdog with a transmitter that never acknowledges.
        do_reset();
        u_mute = 1'b1;
        rq[0].push_back(9'h155); rq[1].push_back(9'h166);
        wait_quiet(200, "t4");
        u_mute = 1'b0;
        e = '{0, 1};  check_ids("t4_ids", e);
        check("t4_rx_len", rx_log.size(), 0);
        check("t4_pulses", to_delta.size(), 2);
        for (int i = 0; i < to_delta.size(); i++)
            check($sformatf("t4_delay[%0d]", i), to_delta[i], TO);

        // Reset while the first byte is draining.
        do_reset();
        u_d = 1; u_f = 10;
        rq[0].push_back(9'h150); rq[1].push_back(9'h151);
        n = 0;
        while (!(m_out && m_since == 5) && n < 200) begin
            @(posedge wb_clk_i);
            n++;
        end
        check("t5_reached_drain", n < 200, 1);
        check("t5_pre_tx_start", tx_start, 1);
        #3 wb_rst_i = 1'b1;
        #1;
        check("t5_rst_tx_start", tx_start, 0);
        check("t5_rst_req_ready", req_ready, 0);
        check("t5_rst_timeout", timeout_err, 0);
        rq[0].push_back(9'h152);
        repeat (2) @(posedge wb_clk_i);
        #3 wb_rst_i = 1'b0;
        clear_logs();
        wait_quiet(200, "t5");
        e = '{0, 1};          check_ids("t5_ids", e);
        e = '{8'h52, 8'h51};  check_rx("t5_rx", e);

        // 512-byte packet from requester 3, others queued behind it.
        do_reset();
        u_d = 1; u_f = 2;
        for (int i = 0; i < 512; i++)
            rq[3].push_back({(i == 511) ? 1'b1 : 1'b0, 8'h20 + 8'(i % 95)});
        n = 0;
        while (acc_ids.size() < 1 && n < 100) begin
            @(posedge wb_clk_i);
            n++;
        end
        check("t6_first_accept", acc_ids.size() >= 1, 1);
        rq[0].push_back(9'h1a0); rq[1].push_back(9'h1a1); rq[2].push_back(9'h1a2);
        wait_quiet(4000, "t6");
        e.delete();
        for (int i = 0; i < 512; i++) e.push_back(3);
        e.push_back(0); e.push_back(1); e.push_back(2);
        check_ids("t6_ids", e);
        e.delete();
        for (int i = 0; i < 512; i++) e.push_back(8'h20 + (i % 95));
        e.push_back(8'ha0); e.push_back(8'ha1); e.push_back(8'ha2);
        check_rx("t6_rx", e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL global_timeout: bench did not complete in time");
        $fatal(1, "global timeout");
    end

endmodule
